// File: rtl/lemming_tracker.sv
// lemming_tracker: follows the position, dig depth and fall length of a
// lemming from the one-hot status flags of the upstream walker FSM.
// A fall of more than SPLAT_LIMIT cycles kills the lemming. DEAD is held
// until reset.
// Optional feature: define LEMMING_TRACKER_ERR_EN to flag non-one-hot status
// vectors in a sticky status_err and ignore them. Without the macro they are
// resolved by priority aaah > digging > walk_left > walk_right.
module lemming_tracker #(
   parameter int SPLAT_LIMIT = 20,
   parameter int POS_W       = 8,
   parameter int POS_INIT    = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             walk_left,
   input  logic             walk_right,
   input  logic             aaah,
   input  logic             digging,
   output logic [POS_W-1:0] position,
   output logic [POS_W-1:0] depth,
   output logic [7:0]       fall_cnt,
   output logic             alive,
   output logic             splat,
   output logic             status_err
);

   typedef enum logic [1:0] {
      ST_TRACK = 2'd0,
      ST_FALL  = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   localparam logic [POS_W-1:0] POS_MAX    = {POS_W{1'b1}};
   localparam logic [POS_W-1:0] POS_ZERO   = {POS_W{1'b0}};
   localparam logic [POS_W-1:0] POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0] POS_RST    = POS_W'(POS_INIT);
   localparam logic [7:0]       SPLAT_LIM8 = 8'(SPLAT_LIMIT);
   localparam logic [7:0]       FALL_SAT   = 8'(SPLAT_LIMIT + 1);

   state_t           state_q, state_d;
   logic [POS_W-1:0] position_q, position_d;
   logic [POS_W-1:0] depth_q, depth_d;
   logic [7:0]       fall_cnt_q, fall_cnt_d;
   logic             alive_q, alive_d;
   logic             splat_q, splat_d;
   logic             status_err_q, status_err_d;
   logic             multi_hot_s;

`ifdef LEMMING_TRACKER_ERR_EN
   logic [3:0] status_vec_s;
   assign status_vec_s = {aaah, digging, walk_left, walk_right};
   // More than one bit set: clearing the lowest set bit leaves something behind.
   assign multi_hot_s  = ((status_vec_s & (status_vec_s - 4'd1)) != 4'd0);
`else
   assign multi_hot_s  = 1'b0;
`endif

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_TRACK;
         position_q   <= POS_RST;
         depth_q      <= POS_ZERO;
         fall_cnt_q   <= 8'd0;
         alive_q      <= 1'b1;
         splat_q      <= 1'b0;
         status_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         position_q   <= position_d;
         depth_q      <= depth_d;
         fall_cnt_q   <= fall_cnt_d;
         alive_q      <= alive_d;
         splat_q      <= splat_d;
         status_err_q <= status_err_d;
      end
   end

   // Next-state and counter update; every value holds unless a rule moves it.
   always_comb begin
      state_d      = state_q;
      position_d   = position_q;
      depth_d      = depth_q;
      fall_cnt_d   = fall_cnt_q;
      alive_d      = alive_q;
      splat_d      = splat_q;
      status_err_d = status_err_q;
      if (multi_hot_s && (state_q != ST_DEAD)) begin
         // Ambiguous status: record it and leave everything else untouched.
         status_err_d = 1'b1;
      end else begin
         case (state_q)
            ST_TRACK: begin
               if (aaah) begin
                  state_d    = ST_FALL;
                  fall_cnt_d = 8'd1;
               end else if (digging) begin
                  if (depth_q != POS_MAX) begin
                     depth_d = depth_q + POS_ONE;
                  end else begin
                     depth_d = depth_q;
                  end
               end else if (walk_left) begin
                  if (position_q != POS_ZERO) begin
                     position_d = position_q - POS_ONE;
                  end else begin
                     position_d = position_q;
                  end
               end else if (walk_right) begin
                  if (position_q != POS_MAX) begin
                     position_d = position_q + POS_ONE;
                  end else begin
                     position_d = position_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_FALL: begin
               if (aaah) begin
                  if (fall_cnt_q < FALL_SAT) begin
                     fall_cnt_d = fall_cnt_q + 8'd1;
                  end else begin
                     fall_cnt_d = fall_cnt_q;
                  end
               end else begin
                  // Landing cycle: judge the fall, no movement this cycle.
                  fall_cnt_d = 8'd0;
                  if (fall_cnt_q > SPLAT_LIM8) begin
                     state_d = ST_DEAD;
                     splat_d = 1'b1;
                     alive_d = 1'b0;
                  end else begin
                     state_d = ST_TRACK;
                  end
               end
            end
            ST_DEAD: begin
               state_d = ST_DEAD;
            end
            default: begin
               state_d = ST_TRACK;
            end
         endcase
      end
   end

   assign position   = position_q;
   assign depth      = depth_q;
   assign fall_cnt   = fall_cnt_q;
   assign alive      = alive_q;
   assign splat      = splat_q;
   assign status_err = status_err_q;

endmodule
